// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: received-frame delivery bus (valid/ready plus per-frame error flags)
interface uart_rx_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_error;
  logic                  frame_error;
  modport master (output rx_data, rx_valid, parity_error, frame_error, input rx_ready);
  modport slave  (input rx_data, rx_valid, parity_error, frame_error, output rx_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver with parity/framing/overrun reporting
module uart_rx_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           rx_clk,
  input  logic           resetn,
  input  logic           os_tick,
  input  logic           rxd,
  input  logic           parity_en,
  input  logic           parity_odd,
  input  logic           two_stop,
  uart_rx_ctrl_if.master rx,
  output logic           overrun,
  output logic           busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;
  localparam logic [2:0] BRK    = 3'd6;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [2:0]             state;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  shift;
  logic                   cfg_par, cfg_odd, cfg_two;
  logic                   perr, ferr;
  logic                   mid, last, ferr_now, done, hs;
  assign rxd_s    = sync_q[SYNC_STAGES-1];
  assign mid      = os_tick && tick_cnt == T_HALF;
  assign last     = os_tick && tick_cnt == T_LAST;
  assign ferr_now = ferr || !rxd_s;
  assign done     = last && ((state == STOP1 && !cfg_two) || state == STOP2);
  assign hs       = rx.rx_valid && rx.rx_ready;
  assign busy     = state != IDLE;
  // metastability synchroniser; resets to the idle (high) line level
  always_ff @(posedge rx_clk or negedge resetn)
    if (!resetn) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  // frame FSM: start validation, mid-bit sampling, parity and stop checks
  always_ff @(posedge rx_clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      cfg_par  <= 1'b0;
      cfg_odd  <= 1'b0;
      cfg_two  <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (os_tick) tick_cnt <= last ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (!rxd_s) begin
            state   <= START;
            cfg_par <= parity_en;
            cfg_odd <= parity_odd;
            cfg_two <= two_stop;
            perr    <= 1'b0;
            ferr    <= 1'b0;
          end
        end
        START:
          if (mid) begin
            state    <= rxd_s ? IDLE : DATA;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        DATA:
          if (last) begin
            shift   <= {rxd_s, shift[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt == B_LAST ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == B_LAST) state <= cfg_par ? PARITY : STOP1;
          end
        PARITY:
          if (last) begin
            perr  <= (^shift ^ rxd_s) != cfg_odd;
            state <= STOP1;
          end
        STOP1:
          if (last) begin
            ferr  <= !rxd_s;
            state <= cfg_two ? STOP2 : (rxd_s ? IDLE : BRK);
          end
        STOP2:
          if (last) begin
            ferr  <= ferr_now;
            state <= ferr_now ? BRK : IDLE;
          end
        BRK:     if (rxd_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // output holding register: deliver on completion, or record an overrun if still unread
  always_ff @(posedge rx_clk or negedge resetn) begin
    if (!resetn) begin
      rx.rx_data      <= '0;
      rx.rx_valid     <= 1'b0;
      rx.parity_error <= 1'b0;
      rx.frame_error  <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      if (hs) begin
        rx.rx_valid <= 1'b0;
        overrun     <= 1'b0;
      end
      if (done) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data      <= shift;
          rx.rx_valid     <= 1'b1;
          rx.parity_error <= perr;
          rx.frame_error  <= ferr_now;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Parametrised UART receive controller, successor to the basic receive FSM.
- Oversamples the serial line, validates the start bit and samples each bit at mid-point, LSB first.
- Handles a configurable data width, optional even/odd parity, and 1 or 2 stop bits.
- Delivers each frame on a valid/ready interface with parity, framing and overrun flags. It sits between the line synchroniser/baud generator and the RX FIFO/host.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9)
OVERSAMPLE, 16, os_tick pulses per bit period (even, >=4)
SYNC_STAGES, 2, flops in the rxd synchroniser (>=2)

Ports:
rx_clk  input  1  receive clock; all flops on rising edge
resetn  input  1  asynchronous active-low reset
os_tick  input  1  one-cycle enable, OVERSAMPLE pulses per bit
rxd  input  1  raw serial line, idle high
parity_en  input  1  1 = frame carries a parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity
two_stop  input  1  1 = two stop bits
rx_data  output  DATA_WIDTH  received word, held while rx_valid is 1
rx_valid  output  1  rx_data holds an unread frame
rx_ready  input  1  consumer accepts; the handshake occurs when rx_valid and rx_ready are both 1
parity_error  output  1  parity mismatch for the frame in rx_data
frame_error  output  1  a stop bit sampled 0 for the frame in rx_data
overrun  output  1  sticky: a frame was dropped because rx_valid was still 1
busy  output  1  state is not IDLE

Behaviour:
- Reset (asynchronous, resetn=0):
  - State IDLE; all counters 0.
  - Synchroniser flops are set to 1.
  - rx_data=0; rx_valid, parity_error, frame_error, overrun and busy are all 0.
- rxd passes through SYNC_STAGES flops, giving rxd_s. All decisions use rxd_s.
- tick_cnt counts os_tick pulses in 0..OVERSAMPLE-1. bit_cnt counts 0..DATA_WIDTH-1.
- Counters advance only on cycles where os_tick=1.
- parity_en, parity_odd and two_stop are latched on entry to START. Changes mid-frame have no effect.

State machine:
- IDLE: rxd_s=0 -> START, tick_cnt=0.
- START: when tick_cnt reaches OVERSAMPLE/2-1, sample rxd_s.
  - Sample 1 (glitch) -> IDLE, no flags.
  - Sample 0 -> DATA, tick_cnt=0, bit_cnt=0.
- DATA: at tick_cnt=OVERSAMPLE-1, sample rxd_s into the shift register, LSB first, and increment bit_cnt.
  - After bit DATA_WIDTH-1 -> PARITY if parity_en, else STOP1.
- PARITY: sample the bit at tick_cnt=OVERSAMPLE-1.
  - perr = (XOR of data bits XOR parity bit) != parity_odd.
  - Then -> STOP1.
- STOP1: sample at tick_cnt=OVERSAMPLE-1.
  - A 0 sample sets ferr.
  - -> STOP2 if two_stop, else the frame completes.
- STOP2: sample the same way, OR-ing into ferr; then the frame completes.
- Frame completion, in the rx_clk cycle after the final stop sample:
  - If rx_valid=0, or the handshake occurs in that same cycle: load rx_data; set rx_valid=1; set parity_error=perr and frame_error=ferr.
  - Otherwise drop the frame, set overrun=1, and leave rx_data and the flags unchanged.
  - Next state: ferr=1 -> BREAK; ferr=0 -> IDLE.
- BREAK: wait for rxd_s=1, then -> IDLE. Prevents a held-low line from being read as repeated frames.
- Handshake: rx_valid clears the cycle after rx_valid and rx_ready are both 1, unless a new frame loads in that same cycle (rx_valid stays 1).
  - overrun clears on any handshake; otherwise it is held until reset.
- Latency: start-bit falling edge at the pin to rx_valid = (1 + DATA_WIDTH + parity_en + 1 + two_stop) bit periods − OVERSAMPLE/2 ticks + SYNC_STAGES + 1 cycles.
- Parity with DATA_WIDTH=9 covers all 9 bits.
- Reset mid-frame: the frame is abandoned and no rx_valid is produced. After reset release, rxd held low is seen as a start only once rxd_s is 0. The synchroniser resets to 1, so a low line after reset begins a START check.

Test Plan:
- 0xA5, no parity, 1 stop, OVERSAMPLE=16 -> rx_valid=1, rx_data=0xA5, both error flags 0. Measured latency matches the formula.
- 0x03 with even parity and parity bit 1 -> parity_error=1. Same frame with parity_odd=1 -> parity_error=0.
- rxd low for 4 os_ticks, then high -> returns to IDLE, no rx_valid. A following valid 0x3C frame is received correctly.
- 0x7E with stop bit 0 and the line held low 3 bit periods -> frame_error=1, one frame only, state BREAK until rxd rises. The next 0x81 frame is clean.
- Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1. On handshake, rx_valid and overrun both clear.
- DATA_WIDTH=7, two_stop=1, odd parity, 0x55 -> rx_data=0x55, no errors. A 0 on the second stop bit -> frame_error=1. Reset asserted mid-DATA -> all outputs 0 immediately.
